// File: rtl/showcase0_result_tx.sv
// ---------------------------------------------------------------------------
// showcase0_result_tx
//   Consumer end of the Showcase0 output interface. On sample_vld the current
//   result inputs are captured as one frame into a small FIFO; frames are then
//   serialized as bytes on a valid/ready stream toward the debug/UART link.
//
//   Frame byte order:
//     HEADER, c[7:0], c[15:8], c[23:16], c[31:24], {f,1'b0,cmp[5:0]},
//     sc_signal, j, k[7:0], k[15:8], k[23:16], k[31:24]
//     [+ XOR of the 12 bytes above when SHOWCASE0_RESULT_TX_CHECKSUM_EN]
//
//   Optional feature macro: SHOWCASE0_RESULT_TX_CHECKSUM_EN
//
// Ports
//   clk, rst_n        clock (posedge), synchronous active-low reset
//   sample_vld        capture c/cmp/sc_signal/j/k/f this cycle
//   c, cmp, sc_signal, j, k, f   Showcase0 result values
//   dout_data/_vld    serialized byte stream, held until dout_rdy
//   dout_rdy          sink accepts byte
//   busy              frame in flight or FIFO non-empty
//   fifo_level        frames stored, excluding the frame in flight
//   drop_cnt          saturating count of samples lost to a full FIFO
// ---------------------------------------------------------------------------
module showcase0_result_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_vld,
  input  logic [31:0]                   c,
  input  logic [5:0]                    cmp,
  input  logic [7:0]                    sc_signal,
  input  logic [7:0]                    j,
  input  logic [31:0]                   k,
  input  logic                          f,
  output logic [7:0]                    dout_data,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [3:0]  LAST_IDX = 4'd11;

  typedef struct packed {
    logic        f;
    logic [31:0] k;
    logic [7:0]  j;
    logic [7:0]  sc;
    logic [5:0]  cmp;
    logic [31:0] c;
  } frame_t;

`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  frame_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [DROP_W-1:0] drop_q;

  state_t          state_q;
  logic [3:0]      idx_q;
  frame_t          frame_q;
  logic [7:0]      dout_data_q;
  logic            dout_vld_q;
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  frame_t          frame_in;
  frame_t          head;
  logic            full, push, pop, hs, frame_done;
  logic [7:0]      next_byte;

  function automatic logic [7:0] frame_byte(input frame_t fr, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = fr.c[7:0];
      4'd2:    b = fr.c[15:8];
      4'd3:    b = fr.c[23:16];
      4'd4:    b = fr.c[31:24];
      4'd5:    b = {fr.f, 1'b0, fr.cmp};
      4'd6:    b = fr.sc;
      4'd7:    b = fr.j;
      4'd8:    b = fr.k[7:0];
      4'd9:    b = fr.k[15:8];
      4'd10:   b = fr.k[23:16];
      4'd11:   b = fr.k[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    frame_in   = '{f: f, k: k, j: j, sc: sc_signal, cmp: cmp, c: c};
    head       = mem_q[rd_ptr_q];
    // Full is judged on the registered level: a pop in the same cycle
    // does not make room for a sample arriving while full.
    full       = (level_q == LW'(FIFO_DEPTH));
    push       = sample_vld && !full;
    hs         = dout_vld_q && dout_rdy;
    frame_done = 1'b0;
    case (state_q)
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
      CSUM:    frame_done = hs;
`else
      SEND:    frame_done = hs && (idx_q == LAST_IDX);
`endif
      default: frame_done = 1'b0;
    endcase
    // Next frame is popped on the last handshake so frames run back to back.
    pop        = (level_q != '0) && ((state_q == IDLE) || frame_done);
    level_d    = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    next_byte  = frame_byte(frame_q, idx_q + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= frame_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (sample_vld && full && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      dout_data_q <= '0;
      dout_vld_q  <= 1'b0;
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q     <= SEND;
            idx_q       <= '0;
            frame_q     <= head;
            dout_data_q <= HEADER;
            dout_vld_q  <= 1'b1;
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
            csum_q      <= HEADER;
`endif
          end
        end
        SEND: begin
          if (hs) begin
            if (idx_q != LAST_IDX) begin
              idx_q       <= idx_q + 4'd1;
              dout_data_q <= next_byte;
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
              // Checksum accumulates as each byte is loaded, so it already
              // covers all 12 bytes when the last one is accepted.
              csum_q      <= csum_q ^ next_byte;
`endif
            end else begin
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
              state_q     <= CSUM;
              dout_data_q <= csum_q;
`else
              if (pop) begin
                idx_q       <= '0;
                frame_q     <= head;
                dout_data_q <= HEADER;
              end else begin
                state_q     <= IDLE;
                dout_vld_q  <= 1'b0;
                dout_data_q <= '0;
              end
`endif
            end
          end
        end
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            if (pop) begin
              state_q     <= SEND;
              idx_q       <= '0;
              frame_q     <= head;
              dout_data_q <= HEADER;
              csum_q      <= HEADER;
            end else begin
              state_q     <= IDLE;
              dout_vld_q  <= 1'b0;
              dout_data_q <= '0;
            end
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          dout_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign dout_data  = dout_data_q;
  assign dout_vld   = dout_vld_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_showcase0_result_tx.sv
// ---------------------------------------------------------------------------
// tb_showcase0_result_tx
//   Scoreboard bench: expected bytes are queued when a sample is driven and
//   compared as the DUT hands bytes off. Inputs change 1 time unit after the
//   rising edge, outputs are observed on the falling edge or after the edge.
// ---------------------------------------------------------------------------
module tb_showcase0_result_tx;

`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_vld;
  logic [31:0] c;
  logic [5:0]  cmp;
  logic [7:0]  sc_signal;
  logic [7:0]  j;
  logic [31:0] k;
  logic        f;
  logic [7:0]  dout_data;
  logic        dout_vld;
  logic        dout_rdy;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;

  showcase0_result_tx #(.FIFO_DEPTH(4), .HEADER(8'hA5), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_vld(sample_vld),
    .c(c), .cmp(cmp), .sc_signal(sc_signal), .j(j), .k(k), .f(f),
    .dout_data(dout_data), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [31:0] cv, input logic [5:0] cmpv,
                              input logic [7:0] scv, input logic [7:0] jv,
                              input logic [31:0] kv, input logic fv);
    logic [7:0] b[12];
    logic [7:0] x;
    b = '{8'hA5, cv[7:0], cv[15:8], cv[23:16], cv[31:24], {fv, 1'b0, cmpv},
          scv, jv, kv[7:0], kv[15:8], kv[23:16], kv[31:24]};
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic sample(input logic [31:0] cv, input logic [5:0] cmpv,
                        input logic [7:0] scv, input logic [7:0] jv,
                        input logic [31:0] kv, input logic fv, input bit keep);
    c = cv; cmp = cmpv; sc_signal = scv; j = jv; k = kv; f = fv;
    sample_vld = 1'b1;
    if (keep) expect_frame(cv, cmpv, scv, jv, kv, fv);
    tick();
    sample_vld = 1'b0;
  endtask

  task automatic sample_rand(input bit keep);
    sample($urandom, 6'($urandom), 8'($urandom), 8'($urandom), $urandom, 1'($urandom), keep);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick(); tick(); tick();
    total++; if (dout_vld !== 1'b0)    begin bad++; $display("FAIL reset_vld: got %0b want 0", dout_vld); end
    total++; if (dout_data !== 8'h00)  begin bad++; $display("FAIL reset_data: got %02h want 00", dout_data); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (fifo_level !== 3'd0)  begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++; if (drop_cnt !== 8'h00)   begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single();
    logic [7:0] lit[12];
    logic [7:0] x;
    logic [7:0] e;
    lit = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'h03, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin exp_q.push_back(lit[i]); x = x ^ lit[i]; end
`ifdef SHOWCASE0_RESULT_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    dout_rdy = 1'b1;
    sample(32'h04030201, 6'b100001, 8'h03, 8'h02, 32'h000000FE, 1'b1, 1'b0);
    total++; if (dout_vld !== 1'b0)   begin bad++; $display("FAIL single_lat1: vld got %0b want 0", dout_vld); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    tick();
    total++; if (dout_vld !== 1'b1)   begin bad++; $display("FAIL single_lat2: vld got %0b want 1", dout_vld); end
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      if (dout_vld && dout_rdy) begin
        e = exp_q.pop_front();
        total++; if (dout_data !== e) begin bad++; $display("FAIL single_byte: got %02h want %02h", dout_data, e); end
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_timeout: left %0d want 0", exp_q.size()); end
    total++; if (dout_vld !== 1'b0)  begin bad++; $display("FAIL single_end_vld: got %0b want 0", dout_vld); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL single_end_busy: got %0b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    dout_rdy = 1'b0;
    for (int i = 0; i < 5; i++) sample_rand(1'b1);
    sample_rand(1'b0);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    total++; if (drop_cnt !== 8'd1)   begin bad++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (dout_vld !== 1'b1 || dout_data !== 8'hA5) begin
      bad++; $display("FAIL ovf_frozen: got vld=%0b data=%02h want 1/a5", dout_vld, dout_data);
    end
    dout_rdy = 1'b1;
    for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      if (dout_vld && dout_rdy) begin
        e = exp_q.pop_front();
        total++; if (dout_data !== e) begin bad++; $display("FAIL ovf_byte: got %02h want %02h", dout_data, e); end
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_timeout: left %0d want 0", exp_q.size()); end
    tick();
    total++; if (dout_vld !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ovf_extra: got vld=%0b busy=%0b want 0/0", dout_vld, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int run;
    bit started;
    bit ended;
    dout_rdy = 1'b1;
    sample_rand(1'b1);
    sample_rand(1'b1);
    run = 0; started = 0; ended = 0;
    for (int n = 0; n < 100 && !ended; n++) begin
      @(negedge clk);
      if (dout_vld) begin
        started = 1;
        run++;
        e = exp_q.pop_front();
        total++; if (dout_data !== e) begin bad++; $display("FAIL b2b_byte: got %02h want %02h", dout_data, e); end
      end else if (started) begin
        ended = 1;
      end
      tick();
    end
    total++; if (run != 2 * FRAME_LEN) begin bad++; $display("FAIL b2b_run: got %0d want %0d", run, 2 * FRAME_LEN); end
  endtask

  task automatic test_reset_mid();
    int hs;
    int seen;
    bit found;
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) sample_rand(1'b0);
    hs = 0; found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (dout_vld && dout_rdy) hs++;
      if (hs == 5) found = 1;
      tick();
    end
    total++; if (!found || fifo_level !== 3'd2) begin
      bad++; $display("FAIL rstmid_setup: got found=%0b level=%0d want 1/2", found, fifo_level);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (dout_vld !== 1'b0)   begin bad++; $display("FAIL rstmid_vld: got %0b want 0", dout_vld); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (dout_vld) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d vld cycles want 0", seen); end
  endtask

  task automatic test_random_rdy();
    logic [7:0] e;
    logic [7:0] hold_data;
    bit hold;
    dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) sample_rand(1'b1);
    hold = 0; hold_data = 8'h00;
    dout_rdy = 1'($urandom_range(0, 1));
    for (int n = 0; n < 500 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      if (hold) begin
        total++; if (dout_vld !== 1'b1 || dout_data !== hold_data) begin
          bad++; $display("FAIL rand_stable: got vld=%0b data=%02h want 1/%02h", dout_vld, dout_data, hold_data);
        end
      end
      hold = dout_vld && !dout_rdy;
      hold_data = dout_data;
      if (dout_vld && dout_rdy) begin
        e = exp_q.pop_front();
        total++; if (dout_data !== e) begin bad++; $display("FAIL rand_byte: got %02h want %02h", dout_data, e); end
      end
      tick();
      dout_rdy = 1'($urandom_range(0, 1));
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_drop_sat();
    do_reset();
    dout_rdy = 1'b0;
    for (int i = 0; i < 300; i++) sample_rand(1'b0);
    total++; if (drop_cnt !== 8'hFF)  begin bad++; $display("FAIL drop_sat: got %02h want ff", drop_cnt); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL drop_level: got %0d want 4", fifo_level); end
    do_reset();
    tick();
    total++; if (drop_cnt !== 8'h00)  begin bad++; $display("FAIL drop_clear: got %02h want 00", drop_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; sample_vld = 1'b0; dout_rdy = 1'b0;
    c = '0; cmp = '0; sc_signal = '0; j = '0; k = '0; f = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random_rdy();
    test_drop_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
